// File: rtl/mmio_unit_pkg.sv
// Shared bus encodings, I/O address map and address decoder for the memory-mapped
// peripheral block (LEDs, switches, keys, timer).
package mmio_unit_pkg;

    localparam logic [1:0] M_NOP   = 2'b00;
    localparam logic [1:0] M_WRITE = 2'b01;
    localparam logic [1:0] M_READ  = 2'b10;

    localparam logic [8:0] ADDR_LED   = 9'h100;
    localparam logic [8:0] ADDR_SW    = 9'h140;
    localparam logic [8:0] ADDR_KEY   = 9'h150;
    localparam logic [8:0] ADDR_TIMER = 9'h160;

    typedef enum logic [1:0] {
        REG_LED   = 2'd0,
        REG_SW    = 2'd1,
        REG_KEY   = 2'd2,
        REG_TIMER = 2'd3
    } io_reg_e;

    typedef struct packed {
        logic    hit;
        io_reg_e sel;
    } io_dec_t;

    // Every mapped address has bit 8 set, so an exact match also implies I/O space.
    function automatic io_dec_t io_decode(input logic [8:0] addr);
        io_dec_t d;
        d.hit = 1'b1;
        d.sel = REG_LED;
        case (addr)
            ADDR_LED:   d.sel = REG_LED;
            ADDR_SW:    d.sel = REG_SW;
            ADDR_KEY:   d.sel = REG_KEY;
            ADDR_TIMER: d.sel = REG_TIMER;
            default:    d.hit = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mmio_unit_sync_fall.sv
// Multi-flop synchronizer for one asynchronous bit, with a one-cycle pulse
// whenever the synchronized value falls from 1 to 0.
module sync_fall #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_fall
);

    logic [STAGES-1:0] r_chain;
    logic              r_prev;

    // Synchronizer chain plus one history flop for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_chain <= {STAGES{RESET_VAL}};
            r_prev  <= RESET_VAL;
        end else begin
            r_chain[0] <= i_async;
            for (int i = 1; i < STAGES; i++) begin
                r_chain[i] <= r_chain[i-1];
            end
            r_prev <= r_chain[STAGES-1];
        end
    end

    assign o_fall = r_prev & ~r_chain[STAGES-1];

endmodule

// File: rtl/mmio_unit.sv
// Memory-mapped I/O block: LED register, synchronized switches, sticky key-press
// status with clear-on-read, and a prescaled 16-bit timer on a shared read bus.
module mmio_unit
    import mmio_unit_pkg::*;
#(
    parameter int PRESCALE    = 50000,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  mem_cmd,
    input  logic [8:0]  mem_addr,
    input  logic [15:0] din,
    output wire  [15:0] mem_data,
    input  logic [9:0]  SW,
    input  logic [3:0]  KEY,
    output logic [7:0]  LEDR
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    io_dec_t       w_dec;
    logic          w_rd;
    logic          w_wr;
    logic          w_key_clr;
    logic          w_tick;
    logic [3:0]    w_key_fall;
    logic [15:0]   w_rd_val;

    logic [7:0]    r_led;
    logic [15:0]   r_rdata;
    logic [3:0]    r_key_status;
    logic          r_key_rd_d;
    logic [PW-1:0] r_presc;
    logic [15:0]   r_timer;
    logic [9:0]    r_sw_sync [SYNC_STAGES];

    assign w_dec     = io_decode(mem_addr);
    assign w_rd      = (mem_cmd == M_READ) && w_dec.hit;
    assign w_wr      = (mem_cmd == M_WRITE) && w_dec.hit;
    // Clear only when a key-status read begins, so a held read clears once.
    assign w_key_clr = w_rd && (w_dec.sel == REG_KEY) && !r_key_rd_d;
    assign w_tick    = (r_presc == PRESC_LAST);

    for (genvar g = 0; g < 4; g++) begin : g_key
        sync_fall #(
            .STAGES    (SYNC_STAGES),
            .RESET_VAL (1'b1)
        ) u_sync (
            .clk     (clk),
            .reset   (reset),
            .i_async (KEY[g]),
            .o_fall  (w_key_fall[g])
        );
    end

    // Switch synchronizer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sw_sync[i] <= 10'd0;
            end
        end else begin
            r_sw_sync[0] <= SW;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sw_sync[i] <= r_sw_sync[i-1];
            end
        end
    end

    // Read-data source for the addressed register.
    always_comb begin
        w_rd_val = 16'h0000;
        case (w_dec.sel)
            REG_LED:   w_rd_val = {8'h00, r_led};
            REG_SW:    w_rd_val = {6'b000000, r_sw_sync[SYNC_STAGES-1]};
            REG_KEY:   w_rd_val = {12'h000, r_key_status};
            REG_TIMER: w_rd_val = r_timer;
            default:   w_rd_val = 16'h0000;
        endcase
    end

    // LED register, registered read data and sticky key status.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_led        <= 8'h00;
            r_rdata      <= 16'h0000;
            r_key_status <= 4'h0;
            r_key_rd_d   <= 1'b0;
        end else begin
            if (w_wr && (w_dec.sel == REG_LED)) begin
                r_led <= din[7:0];
            end
            if (w_rd) begin
                r_rdata <= w_rd_val;
            end
            r_key_status <= (w_key_clr ? 4'h0 : r_key_status) | w_key_fall;
            r_key_rd_d   <= w_rd && (w_dec.sel == REG_KEY);
        end
    end

    // Prescaler and timer; a bus write beats a coincident tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
            r_timer <= 16'h0000;
        end else if (w_wr && (w_dec.sel == REG_TIMER)) begin
            r_presc <= '0;
            r_timer <= din;
        end else if (w_tick) begin
            r_presc <= '0;
            r_timer <= r_timer + 16'd1;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    assign mem_data = w_rd ? r_rdata : 16'bz;
    assign LEDR     = r_led;

endmodule

// File: tb/tb_mmio_unit.sv
// Randomized and directed bench for mmio_unit against a cycle-level behavioural model.
module tb_mmio_unit;

    localparam int P  = 4;
    localparam int NS = 2;
    localparam logic [1:0] C_NOP = 2'b00;
    localparam logic [1:0] C_WR  = 2'b01;
    localparam logic [1:0] C_RD  = 2'b10;

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic [1:0]  mem_cmd  = 2'b00;
    logic [8:0]  mem_addr = 9'h000;
    logic [15:0] din      = 16'h0000;
    logic [9:0]  SW       = 10'h000;
    logic [3:0]  KEY      = 4'hF;
    wire  [15:0] mem_data;
    logic [7:0]  LEDR;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    function automatic bit mapped(input logic [8:0] a);
        return (a == 9'h100) || (a == 9'h140) || (a == 9'h150) || (a == 9'h160);
    endfunction

    // Another bus device answers every read that the I/O block does not own.
    wire other_drv = (mem_cmd == C_RD) && !mapped(mem_addr);
    assign mem_data = other_drv ? 16'hBEEF : 16'bz;

    mmio_unit #(.PRESCALE(P), .SYNC_STAGES(NS)) dut (
        .clk      (clk),
        .reset    (reset),
        .mem_cmd  (mem_cmd),
        .mem_addr (mem_addr),
        .din      (din),
        .mem_data (mem_data),
        .SW       (SW),
        .KEY      (KEY),
        .LEDR     (LEDR)
    );

    // Behavioural model: history of sampled inputs, timer as load value plus elapsed edges.
    logic [7:0]  m_led;
    logic [15:0] m_rdata;
    logic [3:0]  m_status;
    bit          m_prev_key_rd;
    logic [15:0] m_load;
    int          m_n;
    logic [3:0]  kh [4];
    logic [9:0]  sh [4];

    function automatic logic [15:0] m_timer();
        return 16'(int'(m_load) + m_n / P);
    endfunction

    task automatic m_reset();
        m_led = 8'h00; m_rdata = 16'h0000; m_status = 4'h0; m_prev_key_rd = 1'b0;
        m_load = 16'h0000; m_n = 0;
        for (int i = 0; i < 4; i++) begin
            kh[i] = 4'hF;
            sh[i] = 10'h000;
        end
    endtask

    task automatic m_edge();
        logic [15:0] t_now;
        logic [3:0]  press;
        bit rd, wr, clr;
        t_now = m_timer();
        rd    = (mem_cmd == C_RD) && mapped(mem_addr);
        wr    = (mem_cmd == C_WR) && mapped(mem_addr);
        press = ~kh[NS-1] & kh[NS];
        clr   = rd && (mem_addr == 9'h150) && !m_prev_key_rd;
        if (rd) begin
            if (mem_addr == 9'h100)      m_rdata = {8'h00, m_led};
            else if (mem_addr == 9'h140) m_rdata = {6'b0, sh[NS-1]};
            else if (mem_addr == 9'h150) m_rdata = {12'h000, m_status};
            else                         m_rdata = t_now;
        end
        m_status = (clr ? 4'h0 : m_status) | press;
        if (wr && mem_addr == 9'h100) m_led = din[7:0];
        if (wr && mem_addr == 9'h160) begin
            m_load = din;
            m_n    = 0;
        end else begin
            m_n++;
        end
        m_prev_key_rd = rd && (mem_addr == 9'h150);
        for (int i = 3; i > 0; i--) begin
            kh[i] = kh[i-1];
            sh[i] = sh[i-1];
        end
        kh[0] = KEY;
        sh[0] = SW;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) m_reset();
            else m_edge();
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(posedge clk);
            #3;
            chk("ledr", {8'h00, LEDR}, {8'h00, m_led});
            if (mem_cmd == C_RD) begin
                chk("rdbus", mem_data, mapped(mem_addr) ? m_rdata : 16'hBEEF);
            end
        end
    end

    task automatic bus(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d);
        mem_cmd = c; mem_addr = a; din = d;
    endtask

    logic [8:0] addr_tab [8] = '{9'h100, 9'h140, 9'h150, 9'h160, 9'h0FF, 9'h1FF, 9'h120, 9'h050};

    initial begin
        int hold;
        int k;
        int r;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        // Reset state.
        bus(C_RD, 9'h100, 16'h0000); @(negedge clk);
        chk("rst_led_rd", mem_data, 16'h0000);
        bus(C_RD, 9'h160, 16'h0000); @(negedge clk);
        chk("rst_timer_rd", mem_data, 16'h0000);
        // LED write and read back.
        bus(C_WR, 9'h100, 16'h00A5); @(negedge clk);
        chk("led_out", {8'h00, LEDR}, 16'h00A5);
        bus(C_RD, 9'h100, 16'h0000); @(negedge clk);
        chk("led_rd", mem_data, 16'h00A5);
        // Switches and a RAM-space read.
        bus(C_NOP, 9'h000, 16'h0000);
        SW = 10'h3FF;
        repeat (3) @(negedge clk);
        bus(C_RD, 9'h140, 16'h0000); @(negedge clk);
        chk("sw_rd", mem_data, 16'h03FF);
        bus(C_RD, 9'h0FF, 16'h0000); #1;
        chk("ram_space_rd", mem_data, 16'hBEEF);
        @(negedge clk);
        bus(C_NOP, 9'h000, 16'h0000);
        // Key press, held read clears once, second read empty.
        KEY[2] = 1'b0; repeat (5) @(negedge clk);
        KEY = 4'hF;    repeat (3) @(negedge clk);
        bus(C_RD, 9'h150, 16'h0000); @(negedge clk);
        chk("key_rd", mem_data, 16'h0004);
        repeat (2) @(negedge clk);
        bus(C_NOP, 9'h000, 16'h0000); @(negedge clk);
        bus(C_RD, 9'h150, 16'h0000); @(negedge clk);
        chk("key_rd2", mem_data, 16'h0000);
        bus(C_NOP, 9'h000, 16'h0000);
        // Press landing on the clear edge survives.
        KEY[2] = 1'b0; @(negedge clk); @(negedge clk);
        bus(C_RD, 9'h150, 16'h0000); @(negedge clk);
        chk("key_clr_edge", mem_data, 16'h0000);
        bus(C_NOP, 9'h000, 16'h0000); @(negedge clk);
        bus(C_RD, 9'h150, 16'h0000); @(negedge clk);
        chk("key_set_wins", mem_data, 16'h0004);
        bus(C_NOP, 9'h000, 16'h0000);
        KEY = 4'hF;
        // Timer wrap.
        bus(C_WR, 9'h160, 16'hFFFE); @(negedge clk);
        bus(C_NOP, 9'h000, 16'h0000);
        repeat (8) @(negedge clk);
        bus(C_RD, 9'h160, 16'h0000); @(negedge clk);
        chk("timer_wrap", mem_data, 16'h0000);
        // Write coincident with a tick.
        bus(C_WR, 9'h160, 16'h1234); @(negedge clk);
        bus(C_NOP, 9'h000, 16'h0000);
        repeat (3) @(negedge clk);
        bus(C_WR, 9'h160, 16'hABCD); @(negedge clk);
        bus(C_RD, 9'h160, 16'h0000); @(negedge clk);
        chk("timer_wr_wins", mem_data, 16'hABCD);
        // Reset during a held key read with all keys pressed.
        bus(C_WR, 9'h100, 16'h003C);
        KEY = 4'h0; repeat (4) @(negedge clk);
        KEY = 4'hF; repeat (4) @(negedge clk);
        bus(C_RD, 9'h150, 16'h0000); @(negedge clk);
        chk("key_all", mem_data, 16'h000F);
        @(negedge clk);
        reset = 1'b1; #1;
        chk("rst_mid_rd", mem_data, 16'h0000);
        chk("rst_led", {8'h00, LEDR}, 16'h0000);
        repeat (2) @(negedge clk);
        reset = 1'b0; @(negedge clk);
        chk("rst_status", mem_data, 16'h0000);
        bus(C_RD, 9'h160, 16'h0000); @(negedge clk);
        chk("rst_timer", mem_data, 16'h0000);
        bus(C_NOP, 9'h000, 16'h0000); repeat (5) @(negedge clk);
        bus(C_RD, 9'h150, 16'h0000); @(negedge clk);
        chk("no_spurious", mem_data, 16'h0000);
        bus(C_NOP, 9'h000, 16'h0000);
        // Randomized traffic.
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            reset = 1'b0;
            if (hold == 0) begin
                r = $urandom_range(0, 99);
                mem_cmd  = (r < 45) ? C_RD : ((r < 80) ? C_WR : C_NOP);
                mem_addr = ($urandom_range(0, 9) == 0) ? 9'($urandom) : addr_tab[$urandom_range(0, 7)];
                din      = 16'($urandom);
                hold     = $urandom_range(0, 2);
            end else begin
                hold--;
            end
            if ($urandom_range(0, 5) == 0) begin
                k = $urandom_range(0, 3);
                KEY[k] = ~KEY[k];
            end
            if ($urandom_range(0, 15) == 0) SW = 10'($urandom);
            if ($urandom_range(0, 399) == 0) reset = 1'b1;
        end
        @(negedge clk);
        reset = 1'b0;
        bus(C_NOP, 9'h000, 16'h0000);
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mmio_unit.md
MMIO_UNIT -- requirements
Module: mmio_unit

Interface
REQ-001 Parameter PRESCALE, default 50000, meaning clk cycles per timer tick.
REQ-002 Parameter SYNC_STAGES, default 2, meaning synchronizer flop depth for SW and KEY.
REQ-003 Port clk  input  1  system clock; all state updates on posedge clk.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port mem_cmd  input  2  bus command: M_NOP=00, M_READ=10, M_WRITE=01.
REQ-006 Port mem_addr  input  9  bus address; bit 8 set selects the I/O space.
REQ-007 Port din  input  16  write data from the CPU.
REQ-008 Port mem_data  output  16  shared read bus, tri-state; high-Z unless this block is selected for a read.
REQ-009 Port SW  input  10  raw board switches, asynchronous.
REQ-010 Port KEY  input  4  raw board keys, active-low, asynchronous.
REQ-011 Port LEDR  output  8  LED register, driven to LEDR[7:0] at top level.

Function
REQ-012 Address map SHALL be: 0x100 LED (R/W), 0x140 SW (R), 0x150 KEY status (R, clear-on-read), 0x160 TIMER (R/W); all other addresses with bit 8 set are unmapped.
REQ-013 Select SHALL be true when mem_addr[8]=1 and the address is mapped.
REQ-014 A write SHALL occur on posedge clk when mem_cmd=M_WRITE and select is true; writes to SW, KEY or unmapped addresses are ignored.
REQ-015 LED write SHALL load din[7:0] into the LED register; LEDR equals that register.
REQ-016 Read data SHALL be registered: rdata captured on posedge clk when mem_cmd=M_READ and select is true, giving one-cycle read latency, same as RAM.
REQ-017 mem_data SHALL equal rdata while mem_cmd=M_READ and select is true; otherwise 16'bz.
REQ-018 SW read SHALL return {6'b0, SW_sync[9:0]}, where SW_sync is SW after SYNC_STAGES flops.
REQ-019 Each KEY bit SHALL pass through SYNC_STAGES flops; a press is a synchronized 1->0 transition.
REQ-020 KEY status register [3:0] SHALL set the bit for each press and hold it sticky; read returns {12'b0, status}.
REQ-021 Clear-on-read SHALL happen only on the first cycle of a KEY-status read (select rising for 0x150), so a held read clears once.
REQ-022 If a press and a clear occur in the same cycle, the new press SHALL remain set (set wins).
REQ-023 The prescaler SHALL count 0..PRESCALE-1 and emit a one-cycle tick on wrap.
REQ-024 The 16-bit TIMER SHALL increment on each tick and wrap 0xFFFF->0x0000.
REQ-025 TIMER write SHALL load din and reset the prescaler to 0; a write SHALL override a coincident tick.
REQ-026 A TIMER read SHALL return the value before any same-edge increment.

Reset
REQ-027 Reset SHALL asynchronously clear the LED register, rdata, KEY status, prescaler, TIMER, and SW synchronizer flops to 0.
REQ-028 Reset SHALL set the KEY synchronizer flops to 1 (released), so reset release causes no spurious press.
REQ-029 Reset mid-read SHALL leave mem_data at 16'h0000 if a read is still asserted, and high-Z otherwise.

Structure
REQ-030 A shared package SHALL hold the M_NOP/M_READ/M_WRITE encodings and the I/O address constants (LED, SW, KEY, TIMER).
REQ-031 One sub-module, sync_fall, SHALL implement a parameterized-depth synchronizer with falling-edge pulse output, instantiated per KEY bit.
REQ-032 The top level SHALL gate RAM writes and reads with ~mem_addr[8] and connect mmio_unit to the same mem_data bus.

Verification
REQ-033 Write 0x00A5 to 0x100 -> LEDR=8'hA5 the next cycle; read 0x100 -> mem_data=0x00A5 one cycle after mem_cmd=M_READ.
REQ-034 SW=10'h3FF, wait 3 cycles, read 0x140 -> 0x03FF; read 0x0FF (RAM space) -> mem_data not driven by mmio_unit.
REQ-035 Pulse KEY[2] low for 5 cycles, read 0x150 for 3 held cycles -> 0x0004; a second read -> 0x0000; a press landing on the clear cycle -> 0x0004 retained.
REQ-036 PRESCALE=4: write 0xFFFE to 0x160, wait 8 cycles -> TIMER=0x0000 (wrapped); a write coincident with a tick -> the written value wins.
REQ-037 Assert reset during a held KEY read with status=0xF -> status=0, LEDR=0, TIMER=0, and no press flagged after release.
